// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: state encoding,
// per-boundary payload widths and control-field bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } stage_state_e;

    localparam int unsigned DEF_DATA_W    = 128;
    localparam int unsigned DEF_CTRL_W    = 16;
    localparam int unsigned DEF_CNT_W     = 16;

    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned IF_ID_CTRL_W  = 1;
    localparam int unsigned ID_EX_DATA_W  = 128;
    localparam int unsigned ID_EX_CTRL_W  = 16;
    localparam int unsigned EX_MEM_DATA_W = 80;
    localparam int unsigned EX_MEM_CTRL_W = 8;
    localparam int unsigned MEM_WB_DATA_W = 48;
    localparam int unsigned MEM_WB_CTRL_W = 4;

    // Control payload layout, shared by decode and every consuming stage.
    localparam int unsigned CTRL_REG_WR    = 0;
    localparam int unsigned CTRL_MEM_WR    = 1;
    localparam int unsigned CTRL_MEM_RD    = 2;
    localparam int unsigned CTRL_BRANCH    = 3;
    localparam int unsigned CTRL_JUMP      = 4;
    localparam int unsigned CTRL_ALUOP_LSB = 5;
    localparam int unsigned CTRL_ALUOP_W   = 4;

    // The state encoding doubles as the held-entry count.
    function automatic logic [1:0] occupancy_of(stage_state_e s);
        return logic'(s == StFull) ? 2'd2 : (s == StOne) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter for pipeline stage statistics; updates on the
// falling clock edge like the stage it observes.
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned CNT_W  = DEF_CNT_W
`endif
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    stage_state_e      state_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic              in_fire, out_fire;

    // in_ready depends only on state, so out_ready never reaches it combinationally.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(negedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_q     <= StOne;
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                    end else if (in_fire) begin
                        state_q     <= StFull;
                        skid_data_q <= in_data;
                        skid_ctrl_q <= in_ctrl;
                    end else if (out_fire) begin
                        state_q     <= StEmpty;
                        main_data_q <= '0;
                        main_ctrl_q <= '0;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        state_q     <= StOne;
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                        skid_data_q <= '0;
                        skid_ctrl_q <= '0;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    assign out_data  = main_data_q;
    // Bubbles must never carry write enables downstream.
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign occupancy = occupancy_of(state_q);

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (Clk),
        .rst_ni (Clrn),
        .inc_i  (out_valid & ~out_ready),
        .cnt_o  (stall_cnt)
    );

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk_i  (Clk),
        .rst_ni (Clrn),
        .inc_i  (~out_valid),
        .cnt_o  (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus hand-written reset,
// and (with PIPE_STAGE_PERF_EN) counter saturation sequences.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    logic          Clk = 1'b0;
    logic          Clrn = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]    stall_cnt;
    logic [3:0]    bubble_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W  (4)
`endif
    ) dut (
        .Clk       (Clk),
        .Clrn      (Clrn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          fl;
        logic          eov;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        logic          eir;
        logic [1:0]    eocc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic iv, logic [DW-1:0] d, logic [CW-1:0] c, logic ordy,
                                logic fl, logic eov, logic [DW-1:0] ed, logic [CW-1:0] ec,
                                logic eir, logic [1:0] eocc);
        vec_t v;
        v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.ed = ed; v.ec = ec; v.eir = eir; v.eocc = eocc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic eov, input logic [DW-1:0] ed,
                              input logic [CW-1:0] ec, input logic eir, input logic [1:0] eocc);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        check({tag, ".out_data"},  32'(out_data),  32'(ed));
        check({tag, ".out_ctrl"},  32'(out_ctrl),  32'(ec));
        check({tag, ".in_ready"},  32'(in_ready),  32'(eir));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(eocc));
    endtask

    // Drive inputs, let one falling edge update the stage, sample 1 time unit later.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
        @(negedge Clk);
        #1;
    endtask

    initial begin
        // Streaming: data 1..8, one per edge, occupancy 1 throughout
        for (int k = 1; k <= 8; k++) begin
            add(1'b1, DW'(k), CW'(16'h0100 | k), 1'b1, 1'b0,
                1'b1, DW'(k), CW'(16'h0100 | k), 1'b1, 2'd1);
        end
        add(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
        // Backpressure: 0x10 then 0x11, skid fills, order preserved on drain
        add(1'b1, 16'h10, 16'h3, 1'b0, 1'b0, 1'b1, 16'h10, 16'h3, 1'b1, 2'd1);
        add(1'b1, 16'h11, 16'h4, 1'b0, 1'b0, 1'b1, 16'h10, 16'h3, 1'b0, 2'd2);
        add(1'b1, 16'h12, 16'h5, 1'b0, 1'b0, 1'b1, 16'h10, 16'h3, 1'b0, 2'd2);
        add(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h11, 16'h4, 1'b1, 2'd1);
        add(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
        // Bubble gating: ctrl input ignored while no instruction enters
        for (int k = 0; k < 3; k++) begin
            add(1'b0, 16'hBEEF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
        end
        // Flush in FULL discards the simultaneous 0x55
        add(1'b1, 16'h20, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h20, 16'hFFFF, 1'b1, 2'd1);
        add(1'b1, 16'h21, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h20, 16'hFFFF, 1'b0, 2'd2);
        add(1'b1, 16'h55, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
        add(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
        // Flush from EMPTY drops the in_fire
        add(1'b1, 16'h56, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
        // Flush together with out_fire
        add(1'b1, 16'h30, 16'h7, 1'b0, 1'b0, 1'b1, 16'h30, 16'h7, 1'b1, 2'd1);
        add(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);

        #1;
        check_outs("reset", 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
        @(posedge Clk);
        Clrn = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].fl);
            check_outs($sformatf("vec%0d", i), vecs[i].eov, vecs[i].ed, vecs[i].ec,
                       vecs[i].eir, vecs[i].eocc);
        end

        // Asynchronous reset between edges while FULL
        step(1'b1, 16'hA1, 16'hC1, 1'b0, 1'b0);
        step(1'b1, 16'hA2, 16'hC2, 1'b0, 1'b0);
        check_outs("pre_rst", 1'b1, 16'hA1, 16'hC1, 1'b0, 2'd2);
        #2;
        Clrn = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
        @(posedge Clk);
        Clrn = 1'b1;
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        check_outs("post_rst", 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
        step(1'b1, 16'h77, 16'h9, 1'b1, 1'b0);
        check_outs("post_rst_in", 1'b1, 16'h77, 16'h9, 1'b1, 2'd1);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        check_outs("post_rst_drain", 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);

`ifdef PIPE_STAGE_PERF_EN
        Clrn = 1'b0;
        #1;
        check("perf_rst.stall", 32'(stall_cnt), 32'd0);
        check("perf_rst.bubble", 32'(bubble_cnt), 32'd0);
        @(posedge Clk);
        Clrn = 1'b1;
        step(1'b1, 16'h1, 16'h1, 1'b0, 1'b0);
        check("perf_fill.stall", 32'(stall_cnt), 32'd0);
        check("perf_fill.bubble", 32'(bubble_cnt), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            if (k == 10) check("perf_stall10", 32'(stall_cnt), 32'd10);
        end
        check("perf_stall_sat", 32'(stall_cnt), 32'd15);
        check("perf_bubble_hold", 32'(bubble_cnt), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline register, the successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque data payload and a control payload between two pipeline stages. It adds a valid/ready handshake with a 2-entry skid buffer, so stalls never drop or duplicate an instruction, plus a synchronous flush that turns the stage into a bubble. Each CPU stage boundary instantiates one copy with its own widths.

Parameters:
DATA_W, 128, width of the datapath payload (PC4, bus values, immediates, register numbers, ...).
CTRL_W, 16, width of the control payload (RegWr, MemWr, Branch, ALUop, ...); forced to zero whenever a slot is invalid.
CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
Clk  in  1  pipeline clock; all state updates on the negative edge.
Clrn  in  1  asynchronous active-low reset.
flush  in  1  synchronous squash of all held entries (branch/jump taken).
in_valid  in  1  upstream stage presents an instruction.
in_ready  out  1  stage can accept; registered, equals NOT skid_valid.
in_data  in  DATA_W  upstream datapath payload.
in_ctrl  in  CTRL_W  upstream control payload.
out_valid  out  1  downstream slot holds a valid instruction.
out_ready  in  1  downstream stage consumes this cycle.
out_data  out  DATA_W  datapath payload to downstream stage.
out_ctrl  out  CTRL_W  control payload; all zeros when out_valid=0.
occupancy  out  2  number of held entries (0, 1 or 2).

Behaviour:
- Clrn=0 (asynchronous, any time, including mid-stall):
  - out_valid=0, out_data=0, out_ctrl=0.
  - skid entry cleared.
  - in_ready=1, occupancy=0, state EMPTY.
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Both are sampled at the negedge.
- States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (main and skid valid).
- EMPTY:
  - in_fire -> ONE, main <= in.
- ONE:
  - in_fire & out_fire -> ONE, main <= in.
  - in_fire & !out_ready -> FULL, skid <= in.
  - !in_fire & out_fire -> EMPTY; main ctrl/data zeroed.
  - otherwise hold.
- FULL:
  - in_ready=0, so there is never an in_fire.
  - out_fire -> ONE, main <= skid, skid cleared.
  - otherwise hold.
- Latency: 1 edge from in_fire into an EMPTY stage to out_valid=1. Throughput is 1 per cycle while out_ready stays high.
- Ordering: strictly FIFO; the skid entry is always older than any later input.
- flush=1 has highest priority below reset:
  - next state EMPTY; out_valid=0, out_ctrl=0, out_data=0; skid cleared; in_ready=1 next cycle.
  - any in_fire in the same cycle is discarded.
  - flush together with out_fire: the output is consumed downstream this cycle, then the stage empties.
- Control zeroing: an invalid slot always presents ctrl=0, so a bubble cannot write the register file or memory.
- No combinational path from out_ready to in_ready.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined:
  - adds outputs stall_cnt[CNT_W] and bubble_cnt[CNT_W], both reset to 0.
  - stall_cnt increments on each negedge with out_valid & !out_ready.
  - bubble_cnt increments on each negedge with !out_valid (flush included).
  - both saturate at all-ones and never wrap.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - state encoding typedef (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - per-boundary width constants (ID_EX_DATA_W, ID_EX_CTRL_W, EX_MEM_*, ...);
  - control-field bit-position constants shared by decode and consumers.
- Sub-module pipe_perf_cnt: one saturating counter, instantiated twice under PIPE_STAGE_PERF_EN.
- The skid/main storage stays in the top module.

Test Plan:
- Reset mid-stream:
  - stimulus: fill to FULL (data 0xA1, then 0xA2), then assert Clrn=0 between edges.
  - response: out_valid=0, out_ctrl=0, in_ready=1, occupancy=0 immediately, without waiting for a clock edge.
- Streaming:
  - stimulus: in_valid=1 and out_ready=1 throughout, data 1..8.
  - response: out_data=1..8 on consecutive edges, one edge after input; occupancy stays 1; in_ready stays 1.
- Backpressure:
  - stimulus: present 0x10 then 0x11, with out_ready=0 from the second edge.
  - response: occupancy=2 and in_ready=0; then raise out_ready.
  - response: 0x10 then 0x11 appear in order, with no loss or duplicate.
- Flush in FULL:
  - stimulus: FULL with ctrl=0xFFFF, then flush=1 with in_valid=1 (data 0x55).
  - response: next edge out_valid=0, out_ctrl=0, occupancy=0; 0x55 is never output.
- Bubble gating:
  - stimulus: in_valid=0 for 3 cycles.
  - response: out_ctrl=0 on all 3 cycles, regardless of in_ctrl=0xFFFF.
- Performance counters (PIPE_STAGE_PERF_EN, CNT_W=4):
  - stimulus: hold a stall for 20 cycles.
  - response: stall_cnt saturates at 15 and does not wrap; bubble_cnt counts only the cycles with out_valid=0.
